mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles a granted transfer waits for MMU completion before abort.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  fetch port request, read-only, held until if_ack.
REQ-005 if_addr  input  24  fetch byte address.
REQ-006 if_count  input  2  fetch byte count minus 1.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetch data, valid while if_ack is high.
REQ-009 d_req  input  1  data port request, held until d_ack.
REQ-010 d_we  input  1  data port direction: 1 write, 0 read.
REQ-011 d_addr  input  24  data byte address.
REQ-012 d_wdata  input  32  data write value, little-endian.
REQ-013 d_count  input  2  data byte count minus 1.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 d_rdata  output  32  data read value, valid while d_ack is high.
REQ-016 err  output  1  one-cycle pulse with the ack of an aborted (timed-out) transfer.
REQ-017 mmu_address, mmu_dataIn, mmu_byteCount  outputs  24/32/2  MMU request fields.
REQ-018 mmu_read, mmu_write  outputs  1/1  MMU read/write strobes, never both high.
REQ-019 mmu_dataOut  input  32  MMU read data.
REQ-020 mmu_dataOutReady, mmu_dataInReady  inputs  1/1  MMU read/write completion pulses.

Function
REQ-021 FSM states IDLE, BUSY, DONE; arbitration occurs only in IDLE.
REQ-022 IDLE: if any req is high, pick a winner, latch its address/count/wdata/direction into registers, go to BUSY next edge.
REQ-023 Simultaneous requests: round-robin, winner is the port not granted last; after reset the data port has priority.
REQ-024 BUSY: drive latched fields to MMU, hold mmu_read (fetch or d_we=0) or mmu_write (d_we=1) high; requester input changes are ignored.
REQ-025 BUSY completion: a read completes only on mmu_dataOutReady, a write only on mmu_dataInReady; the other ready is ignored.
REQ-026 On completion: register mmu_dataOut into the winner's rdata (writes leave rdata unchanged), pulse the winner's ack on the next cycle, enter DONE.
REQ-027 DONE: mmu_read=mmu_write=0, ack high for exactly this one cycle, return to IDLE next edge.
REQ-028 Requester lowers req in the cycle following ack; a req still high in IDLE after DONE is treated as a new request.
REQ-029 Timeout: a BUSY cycle counter that reaches TIMEOUT with no completion drops strobes, enters DONE with ack=1, err=1, rdata=0.
REQ-030 No preemption: a later higher-priority request waits until IDLE.
REQ-031 Exactly one ack per grant; if_ack and d_ack are never high together.
REQ-032 Latency from grant to ack = MMU latency + 2 cycles (latch in IDLE, ack in DONE).

Reset
REQ-033 On rst: state IDLE, counter 0, all mmu_* outputs 0, if_ack=d_ack=err=0, if_rdata=d_rdata=0, last-grant=fetch (data wins first tie).
REQ-034 rst during BUSY abandons the transfer without ack; strobes are 0 on the cycle after the reset edge.

Structure
REQ-035 Package mem_arb_pkg holds the state enum, port-id constants (PORT_FETCH, PORT_DATA) and the default TIMEOUT.
REQ-036 One sub-module rr_arbiter2: two-way combinational round-robin picker with a registered last-grant bit.

Verification
REQ-037 Fetch read addr 0x000100 count 3 against the MMU ROM -> single if_ack, if_rdata=0x05ADBA05, err=0.
REQ-038 Data write 0x000010 wdata 0xDEADBEEF count 3, then read back -> d_ack twice, d_rdata=0xDEADBEEF.
REQ-039 Both req high from reset, repeated three times -> grant order data, fetch, data; never two acks together.
REQ-040 MMU ready tied low, TIMEOUT=8 -> strobe drops after 8 BUSY cycles, ack+err pulse, rdata=0.
REQ-041 rst asserted mid-BUSY -> no ack, mmu_read=0 next cycle, then a fresh request completes normally.
REQ-042 d_addr changed while BUSY -> MMU sees the originally latched address for the whole transfer.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port MMU arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_FETCH      = 1'b0;
  localparam logic PORT_DATA       = 1'b1;
  localparam int   DEFAULT_TIMEOUT = 64;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 2;

  // One requester's transfer as seen at the arbitration point.
  typedef struct packed {
    logic               port;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [COUNT_W-1:0] count;
    logic [DATA_W-1:0]  wdata;
  } xfer_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: combinational winner, registered last-grant bit.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_fetch,
  input  logic req_data,
  input  logic update,
  output logic valid,
  output logic winner
);

  logic last_grant;

  // NOTE: every output of this block is assigned first so no path leaves it unassigned (no latch).
  always_comb begin
    valid  = req_fetch | req_data;
    winner = PORT_FETCH;
    if (req_fetch && req_data) begin
      winner = ~last_grant;
    end else if (req_data) begin
      winner = PORT_DATA;
    end
  end

  // Starting from "fetch was last" hands the first tie to the data port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_FETCH;
    end else if (update) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto one MMU
// request channel, with a per-transfer completion timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [23:0]       if_addr,
  input  logic [1:0]        if_count,
  output logic              if_ack,
  output logic [31:0]       if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [23:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_count,
  output logic              d_ack,
  output logic [31:0]       d_rdata,

  output logic              err,

  output logic [23:0]       mmu_address,
  output logic [31:0]       mmu_dataIn,
  output logic [1:0]        mmu_byteCount,
  output logic              mmu_read,
  output logic              mmu_write,
  input  logic [31:0]       mmu_dataOut,
  input  logic              mmu_dataOutReady,
  input  logic              mmu_dataInReady
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic             cur_port;
  logic             cur_we;

  logic             arb_valid;
  logic             arb_winner;
  logic             grant;
  xfer_t            pick;
  logic             complete;
  logic             expired;

  assign grant = (state == IDLE) && arb_valid;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_fetch (if_req),
    .req_data  (d_req),
    .update    (grant),
    .valid     (arb_valid),
    .winner    (arb_winner)
  );

  always_comb begin
    pick = '0;
    if (arb_winner == PORT_DATA) begin
      pick.port  = PORT_DATA;
      pick.we    = d_we;
      pick.addr  = d_addr;
      pick.count = d_count;
      pick.wdata = d_wdata;
    end else begin
      pick.port  = PORT_FETCH;
      pick.we    = 1'b0;
      pick.addr  = if_addr;
      pick.count = if_count;
    end
  end

  // Only the ready matching the latched direction finishes a transfer.
  assign complete = cur_we ? mmu_dataInReady : mmu_dataOutReady;
  assign expired  = (busy_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy_cnt      <= '0;
      cur_port      <= PORT_FETCH;
      cur_we        <= 1'b0;
      mmu_address   <= '0;
      mmu_dataIn    <= '0;
      mmu_byteCount <= '0;
      mmu_read      <= 1'b0;
      mmu_write     <= 1'b0;
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      err           <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      // NOTE: pulses default low here; a later non-blocking assignment in the same edge overrides it.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (arb_valid) begin
            cur_port      <= pick.port;
            cur_we        <= pick.we;
            mmu_address   <= pick.addr;
            mmu_dataIn    <= pick.wdata;
            mmu_byteCount <= pick.count;
            mmu_read      <= ~pick.we;
            mmu_write     <= pick.we;
            busy_cnt      <= '0;
            state         <= BUSY;
          end
        end

        BUSY: begin
          if (complete || expired) begin
            mmu_read  <= 1'b0;
            mmu_write <= 1'b0;
            err       <= ~complete;
            state     <= DONE;
            if (cur_port == PORT_DATA) begin
              d_ack <= 1'b1;
              if (!complete)    d_rdata <= '0;
              else if (!cur_we) d_rdata <= mmu_dataOut;
            end else begin
              if_ack <= 1'b1;
              if (!complete) if_rdata <= '0;
              else           if_rdata <= mmu_dataOut;
            end
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
